// File: rtl/fetch_controller_if.sv
// Fetch bus: instruction memory read handshake plus
// instruction register / decode handshake.
interface fetch_controller_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ir_write;
  logic [31:0] ir_data;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output ir_write,
    output ir_data,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  ir_write,
    input  ir_data,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/fetch_controller.sv
// Multi-cycle fetch sequencer: req/ack word reads, IR
// write strobe, valid/ready issue, redirects and timeout.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                pc,
  output logic                       fetch_fault,
  output logic [2:0]                 state,
  fetch_controller_if.master         bus
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    ISSUE = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t        st, st_n;
  logic [31:0]   fetch_pc, fpc_n;
  logic [31:0]   addr_q, addr_n;
  logic [31:0]   pc_q, pc_n;
  logic [31:0]   ir_q, ir_n;
  logic          drop, drop_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      drop     <= 1'b0;
      cnt      <= '0;
    end else begin
      st       <= st_n;
      fetch_pc <= fpc_n;
      addr_q   <= addr_n;
      pc_q     <= pc_n;
      ir_q     <= ir_n;
      drop     <= drop_n;
      cnt      <= cnt_n;
    end
  end

  always_comb begin
    st_n   = st;
    fpc_n  = fetch_pc;
    addr_n = addr_q;
    pc_n   = pc_q;
    ir_n   = ir_q;
    drop_n = drop;
    cnt_n  = cnt;
    start  = 1'b0;
    unique case (st)
      IDLE: begin
        if (enable) begin
          st_n  = FETCH;
          start = 1'b1;
        end
      end
      FETCH: begin
        cnt_n = cnt + 1'b1;
        if (redirect) drop_n = 1'b1;
        if (bus.mem_ack) begin
          // A redirect landing on the ack cycle also kills the word
          if (drop || redirect) begin
            drop_n = 1'b0;
            st_n   = enable ? FETCH : IDLE;
            start  = enable;
          end else begin
            ir_n = bus.mem_rdata;
            st_n = LOAD;
          end
        end else if (cnt == CNT_LAST) begin
          st_n   = FAULT;
          drop_n = 1'b0;
        end
      end
      LOAD: begin
        pc_n  = addr_q;
        fpc_n = fetch_pc + 32'd4;
        if (redirect) begin
          st_n  = enable ? FETCH : IDLE;
          start = enable;
        end else begin
          st_n = ISSUE;
        end
      end
      ISSUE: begin
        if (redirect || bus.instr_ready) begin
          st_n  = enable ? FETCH : IDLE;
          start = enable;
        end
      end
      FAULT: begin
        if (redirect) begin
          st_n  = enable ? FETCH : IDLE;
          start = enable;
        end
      end
      default: st_n = IDLE;
    endcase
    if (redirect) fpc_n = {redirect_pc[31:2], 2'b00};
    // New request address comes from the post-update fetch PC
    if (start) begin
      addr_n = fpc_n;
      cnt_n  = '0;
    end
  end

  assign bus.mem_req     = (st == FETCH);
  assign bus.mem_addr    = addr_q;
  assign bus.ir_write    = (st == LOAD);
  assign bus.ir_data     = ir_q;
  assign bus.instr_valid = (st == ISSUE);
  assign pc              = pc_q;
  assign fetch_fault     = (st == FAULT);
  assign state           = st;

endmodule
